// File: rtl/lce_pkg.sv
// Shared constants for the local-contrast-enhancement frame sequencer:
// 4-bit state encodings, default geometry and a width helper.
package lce_pkg;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_PAD  = 4'd2;
  localparam logic [3:0] S_WIN  = 4'd3;
  localparam logic [3:0] S_HIST = 4'd4;
  localparam logic [3:0] S_CDF  = 4'd5;
  localparam logic [3:0] S_SHOW = 4'd6;
  localparam logic [3:0] S_ADV  = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;
  localparam logic [3:0] S_ERR  = 4'd9;

  localparam int DEF_IMG_W   = 150;
  localparam int DEF_IMG_H   = 150;
  localparam int DEF_TIMEOUT = 4096;

  // Bits needed to index n items; never less than one so 1-pixel images still get a port.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True for the handshake states that wait on a done input and are watched by the watchdog.
  function automatic logic is_stage(input logic [3:0] s);
    return (s >= S_LOAD) && (s <= S_SHOW);
  endfunction

endpackage

// File: rtl/lce_pix_counter.sv
// Raster pixel counter: col/row plus a running linear index kept in step
// with them, so row*IMG_W+col never needs a multiplier.
module lce_pix_counter
  import lce_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int COL_W = width_of(IMG_W),
  parameter int ROW_W = width_of(IMG_H),
  parameter int PIX_W = width_of(IMG_W * IMG_H)
) (
  input  logic             clk,
  input  logic             re_n,
  input  logic             clr,
  input  logic             adv,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [PIX_W-1:0] pixcel,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  assign last = (col == COL_LAST) && (row == ROW_LAST);

  // Step through the raster; the last pixel holds until the next frame clears it.
  // NOTE: state is written with <= only, and reset is tested inside the clocked block, so it is synchronous.
  always_ff @(posedge clk) begin
    if (!re_n || clr) begin
      col    <= '0;
      row    <= '0;
      pixcel <= '0;
    end else if (adv && !last) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
      pixcel <= pixcel + PIX_W'(1);
    end
  end

endmodule

// File: rtl/lce_ctrl_seq.sv
// Frame sequencer for local contrast enhancement. Once per frame it runs
// load and pad, then for every pixel fetch window -> histogram -> CDF -> show,
// each as a strobe/done handshake guarded by a per-stage watchdog.
module lce_ctrl_seq
  import lce_pkg::*;
#(
  parameter int  IMG_W   = DEF_IMG_W,
  parameter int  IMG_H   = DEF_IMG_H,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  parameter int  PIX_W   = width_of(IMG_W * IMG_H),
  parameter int  TO_W    = width_of(TIMEOUT + 1),
  localparam int COL_W   = width_of(IMG_W),
  localparam int ROW_W   = width_of(IMG_H)
) (
  input  logic             clk,
  input  logic             re_n,
  input  logic             start,
  input  logic             abort,
  input  logic             load_c,
  input  logic             pad_i_c,
  input  logic             wf,
  input  logic             hc,
  input  logic             cdf_c,
  input  logic             show_c,
  output logic             load_i,
  output logic             pad_i,
  output logic             re_win,
  output logic             h_s,
  output logic             cdf_s,
  output logic             show_i,
  output logic             busy,
  output logic             frame_done,
  output logic             err_timeout,
  output logic [PIX_W-1:0] pixcel,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [3:0]       state
);

  logic [3:0]      state_nxt;
  logic            entry;       // high in the first (strobe) cycle of every state
  logic            done_sel;
  logic            done_ok;
  logic            wd_expired;
  logic            entering;
  logic            last;
  logic [TO_W-1:0] wd_cnt;

  // Pick the completion input belonging to the current wait state; all others are ignored.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    done_sel = 1'b0;
    case (state)
      S_LOAD:  done_sel = load_c;
      S_PAD:   done_sel = pad_i_c;
      S_WIN:   done_sel = wf;
      S_HIST:  done_sel = hc;
      S_CDF:   done_sel = cdf_c;
      S_SHOW:  done_sel = show_c;
      default: done_sel = 1'b0;
    endcase
  end

  // A done is only honoured after the strobe cycle, so a level held from before cannot skip a stage.
  assign done_ok    = done_sel && !entry;
  assign wd_expired = (TIMEOUT != 0) && is_stage(state) && (wd_cnt == TO_W'(TIMEOUT - 1));
  assign entering   = (state_nxt != state);

  // Next-state decision; abort outranks every other input, a completed stage outranks the watchdog.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_ERR: if (start) state_nxt = S_LOAD;
        S_LOAD: if (done_ok) state_nxt = S_PAD;  else if (wd_expired) state_nxt = S_ERR;
        S_PAD:  if (done_ok) state_nxt = S_WIN;  else if (wd_expired) state_nxt = S_ERR;
        S_WIN:  if (done_ok) state_nxt = S_HIST; else if (wd_expired) state_nxt = S_ERR;
        S_HIST: if (done_ok) state_nxt = S_CDF;  else if (wd_expired) state_nxt = S_ERR;
        S_CDF:  if (done_ok) state_nxt = S_SHOW; else if (wd_expired) state_nxt = S_ERR;
        S_SHOW: if (done_ok) state_nxt = S_ADV;  else if (wd_expired) state_nxt = S_ERR;
        S_ADV:  state_nxt = last ? S_DONE : S_WIN;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register plus one-cycle strobes and status flags, all registered off the entry into a state.
  // err_timeout stays set through an abort to IDLE and is only cleared when a new frame loads.
  always_ff @(posedge clk) begin
    if (!re_n) begin
      state       <= S_IDLE;
      entry       <= 1'b0;
      load_i      <= 1'b0;
      pad_i       <= 1'b0;
      re_win      <= 1'b0;
      h_s         <= 1'b0;
      cdf_s       <= 1'b0;
      show_i      <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      entry      <= entering;
      load_i     <= entering && (state_nxt == S_LOAD);
      pad_i      <= entering && (state_nxt == S_PAD);
      re_win     <= entering && (state_nxt == S_WIN);
      h_s        <= entering && (state_nxt == S_HIST);
      cdf_s      <= entering && (state_nxt == S_CDF);
      show_i     <= entering && (state_nxt == S_SHOW);
      frame_done <= entering && (state_nxt == S_DONE);
      busy       <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
      if (entering && (state_nxt == S_ERR)) begin
        err_timeout <= 1'b1;
      end else if (entering && (state_nxt == S_LOAD)) begin
        err_timeout <= 1'b0;
      end
    end
  end

  // Watchdog: cycles spent in the current handshake state, restarted on every state change.
  always_ff @(posedge clk) begin
    if (!re_n || entering) begin
      wd_cnt <= '0;
    end else if ((TIMEOUT != 0) && is_stage(state)) begin
      wd_cnt <= wd_cnt + TO_W'(1);
    end
  end

  lce_pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W),
    .PIX_W (PIX_W)
  ) u_pix (
    .clk    (clk),
    .re_n   (re_n),
    .clr    (entering && (state_nxt == S_LOAD)),
    .adv    ((state == S_ADV) && !abort),
    .col    (col),
    .row    (row),
    .pixcel (pixcel),
    .last   (last)
  );

endmodule

// File: tb/tb_lce_ctrl_seq.sv
// Bench for lce_ctrl_seq on a 4x3 image with a 16-cycle watchdog.
// The reference model expands a frame into its ordered list of strobe events
// (stage, pixel, due cycle) from the handshake rules and the responder delays
// it chooses; a monitor pops and compares every strobe the DUT emits.
module tb_lce_ctrl_seq;
  import lce_pkg::*;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int TOUT = 16;

  localparam int K_LOAD = 0;
  localparam int K_PAD  = 1;
  localparam int K_WIN  = 2;
  localparam int K_HIST = 3;
  localparam int K_CDF  = 4;
  localparam int K_SHOW = 5;
  localparam int K_DONE = 6;

  typedef struct {
    int kind;
    int pix;
    int due;
  } ev_t;

  logic       clk    = 1'b0;
  logic       re_n   = 1'b0;
  logic       start  = 1'b0;
  logic       abort  = 1'b0;
  logic       man_wf = 1'b0;
  logic [5:0] rsp    = '0;

  logic load_c, pad_i_c, wf, hc, cdf_c, show_c;
  logic load_i, pad_i, re_win, h_s, cdf_s, show_i;
  logic busy, frame_done, err_timeout;
  logic [3:0] pixcel;
  logic [1:0] col;
  logic [1:0] row;
  logic [3:0] state;

  assign load_c  = rsp[K_LOAD];
  assign pad_i_c = rsp[K_PAD];
  assign wf      = rsp[K_WIN] | man_wf;
  assign hc      = rsp[K_HIST];
  assign cdf_c   = rsp[K_CDF];
  assign show_c  = rsp[K_SHOW];

  ev_t sb[$];
  int  dq[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  n_win    = 0;
  int  n_done   = 0;

  lce_ctrl_seq #(
    .IMG_W   (W),
    .IMG_H   (H),
    .TIMEOUT (TOUT),
    .PIX_W   (4),
    .TO_W    (5)
  ) dut (
    .clk         (clk),
    .re_n        (re_n),
    .start       (start),
    .abort       (abort),
    .load_c      (load_c),
    .pad_i_c     (pad_i_c),
    .wf          (wf),
    .hc          (hc),
    .cdf_c       (cdf_c),
    .show_c      (show_c),
    .load_i      (load_i),
    .pad_i       (pad_i),
    .re_win      (re_win),
    .h_s         (h_s),
    .cdf_s       (cdf_s),
    .show_i      (show_i),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout),
    .pixcel      (pixcel),
    .col         (col),
    .row         (row),
    .state       (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Expand a frame starting with LOAD in cycle s into expected events; each
  // stage lasts (delay+1) cycles, SHOW is followed by one ADV cycle. With
  // max_ev>0 the frame is cut after that many events and the final stage gets
  // no responder delay, so it is left waiting.
  task automatic plan(input int s, input int lo, input int hi, input bit win_held,
                      input int max_ev, output int t_last);
    int  total, t, kind, pix, d, n;
    ev_t e;
    total = 3 + 4 * NPIX;
    n = (max_ev <= 0 || max_ev > total) ? total : max_ev;
    t = s;
    t_last = s;
    for (int i = 0; i < n; i++) begin
      if (i == 0)              begin kind = K_LOAD; pix = 0;        end
      else if (i == 1)         begin kind = K_PAD;  pix = 0;        end
      else if (i == total - 1) begin kind = K_DONE; pix = NPIX - 1; end
      else begin
        kind = K_WIN + (i - 2) % 4;
        pix  = (i - 2) / 4;
      end
      e.kind = kind;
      e.pix  = pix;
      e.due  = t;
      sb.push_back(e);
      t_last = t;
      if (kind != K_DONE && i != n - 1) begin
        d = (win_held && kind == K_WIN) ? 1 : int'($urandom_range(hi, lo));
        dq.push_back(d);
        t += d + 1 + ((kind == K_SHOW) ? 1 : 0);
      end
    end
  endtask

  // Responder: answers each strobe after the delay the model chose for it.
  initial begin
    int k, d;
    forever begin
      @(negedge clk);
      if (re_n && ({load_i, pad_i, re_win, h_s, cdf_s, show_i} != 6'b0) && dq.size() > 0) begin
        k = load_i ? K_LOAD : pad_i ? K_PAD : re_win ? K_WIN : h_s ? K_HIST : cdf_s ? K_CDF : K_SHOW;
        d = dq.pop_front();
        repeat (d) @(negedge clk);
        rsp[k] = 1'b1;
        @(posedge clk);
        #1 rsp = '0;
      end
    end
  end

  // Monitor: every strobe or frame_done pulse must match the head of the scoreboard.
  initial begin
    int  n, k;
    ev_t e;
    forever begin
      @(negedge clk);
      n = $countones({load_i, pad_i, re_win, h_s, cdf_s, show_i, frame_done});
      if (n > 1) begin
        check("single_strobe", n, 1);
      end else if (n == 1) begin
        k = load_i ? K_LOAD : pad_i ? K_PAD : re_win ? K_WIN : h_s ? K_HIST :
            cdf_s ? K_CDF : show_i ? K_SHOW : K_DONE;
        if (k == K_WIN)  n_win++;
        if (k == K_DONE) n_done++;
        if (sb.size() == 0) begin
          check("unexpected_event_kind", k, 99);
        end else begin
          e = sb.pop_front();
          check("ev_kind",  k,      e.kind);
          check("ev_pix",   pixcel, e.pix);
          check("ev_row",   row,    e.pix / W);
          check("ev_col",   col,    e.pix % W);
          check("ev_cycle", cyc,    e.due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=cycle %0d required=finish", cyc);
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int s, tl;

    // Power-up reset
    re_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state, S_IDLE);
    check("rst_outs", {load_i, pad_i, re_win, h_s, cdf_s, show_i, frame_done, busy, err_timeout}, 0);
    check("rst_pix", {pixcel, row, col}, 0);
    re_n = 1'b1;

    // Full frame, every responder answers one cycle after its strobe
    n_win = 0;
    pulse_start(s);
    plan(s, 1, 1, 1'b0, 0, tl);
    wait_until(tl + 3);
    check("f1_win_pulses", n_win, NPIX);
    check("f1_frame_done", n_done, 1);
    check("f1_idle", state, S_IDLE);
    check("f1_busy", busy, 0);
    check("f1_pix_hold", pixcel, NPIX - 1);

    // wf held high all frame; start while busy and start in the DONE cycle are ignored
    man_wf = 1'b1;
    pulse_start(s);
    plan(s, 1, 4, 1'b1, 0, tl);
    wait_until(s + 20);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_until(tl);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("f2_idle", state, S_IDLE);
    check("f2_busy", busy, 0);
    man_wf = 1'b0;

    // Random responder delays 1..8
    repeat (3) begin
      pulse_start(s);
      plan(s, 1, 8, 1'b0, 0, tl);
      wait_until(tl + 2);
    end
    check("rnd_frame_done", n_done, 5);
    check("rnd_no_err", err_timeout, 0);

    // abort together with wf in the second WIN cycle of pixel 5
    pulse_start(s);
    plan(s, 1, 3, 1'b0, 2 + 4 * 5 + 1, tl);
    wait_until(tl + 1);
    abort  = 1'b1;
    man_wf = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    man_wf = 1'b0;
    @(negedge clk);
    check("abort_idle", state, S_IDLE);
    check("abort_busy", busy, 0);
    check("abort_pix", pixcel, 5);
    check("abort_rowcol", {row, col}, {2'd1, 2'd1});
    repeat (10) @(negedge clk);
    check("abort_pix_hold", pixcel, 5);
    check("abort_no_done", n_done, 5);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_beats_start", state, S_IDLE);

    // Reset for two cycles in the middle of HIST of pixel 2
    pulse_start(s);
    plan(s, 1, 2, 1'b0, 2 + 4 * 2 + 2, tl);
    wait_until(tl + 1);
    re_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_state", state, S_IDLE);
    check("midrst_outs", {load_i, pad_i, re_win, h_s, cdf_s, show_i, frame_done, busy, err_timeout}, 0);
    check("midrst_pix", {pixcel, row, col}, 0);
    re_n = 1'b1;

    // hc withheld: watchdog fires after 16 HIST cycles
    pulse_start(s);
    plan(s, 1, 5, 1'b0, 4, tl);
    wait_until(tl + TOUT - 1);
    check("to_still_hist", state, S_HIST);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_err_state", state, S_ERR);
    check("to_err_flag", err_timeout, 1);
    check("to_busy_after", busy, 0);
    repeat (5) @(negedge clk);
    check("to_sticky", {state, err_timeout}, {S_ERR, 1'b1});
    pulse_start(s);
    plan(s, 1, 1, 1'b0, 1, tl);
    wait_until(s);
    check("err_restart_clear", err_timeout, 0);
    check("err_restart_busy", busy, 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("final_idle", state, S_IDLE);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
